// File: rtl/scan_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_display_pkg
//  Description : Shared constants for the multiplexed 7-segment controller:
//                active-low hex font, blank pattern, brightness width.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_display_pkg;

    localparam int         BRIGHT_W  = 3;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

    // Active-low {a,b,c,d,e,f,g}; bit 6 is segment a. b and d are lowercase.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage
`default_nettype wire

// File: rtl/scan_display_ctrl_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational hex nibble to active-low 7-segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Straight font lookup; the table covers all 16 codes so no default needed
    assign pattern = SEG_FONT[nibble];

endmodule
`default_nettype wire

// File: rtl/scan_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_display_ctrl
//  Description : Time-multiplexed common-anode 7-segment scanner with
//                per-digit dp/blank, leading-zero suppression, 8-level PWM
//                brightness and frame-boundary shadow loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_display_ctrl
    import scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     bright,
    input  logic                    update_req,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick,
    output logic                    update_pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one_hot0 = NUM_DIGITS'(1);

    logic [DIV_LOG2-1:0]     r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_pending;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                    w_term;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_zero_tail;
    logic                    w_run;
    logic [3:0]              w_nib;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic                    w_sel_zt;
    logic                    w_suppress;
    logic                    w_visible;
    logic [BRIGHT_W-1:0]     w_phase;
    logic                    w_an_on;
    logic [6:0]              w_font;

    assign w_term = &r_presc;
    assign w_wrap = w_term && (r_idx == c_last_idx);

    // Prescaler and digit index; the index steps on the prescaler terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= r_presc + DIV_LOG2'(1);
            if (w_term) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Shadow registers only change at the frame wrap so a frame never mixes data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_wrap) begin
                if (r_pending || update_req) begin
                    r_sh_digits <= digits_in;
                    r_sh_dp     <= dp_in;
                    r_sh_blank  <= blank_in;
                end
                r_pending <= 1'b0;
            end else if (update_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Per-digit selection plus the "this digit and everything left of it is zero" mask
    always_comb begin
        w_run       = 1'b1;
        w_zero_tail = '0;
        w_nib       = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_zt    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run          = w_run && (r_sh_digits[4*k +: 4] == 4'h0);
            w_zero_tail[k] = w_run;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_sh_digits[4*k +: 4];
                w_sel_dp    = r_sh_dp[k];
                w_sel_blank = r_sh_blank[k];
                w_sel_zt    = w_zero_tail[k];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (w_nib),
        .pattern (w_font)
    );

    // Digit 0 is never suppressed so an all-zero value still shows a single 0
    assign w_suppress = lz_en && (r_idx != '0) && w_sel_zt;
    assign w_visible  = !w_sel_blank && !w_suppress;

    // Anode on while the slot phase is within the brightness, minus the
    // first and last cycle of each slot which act as anti-ghosting guards
    assign w_phase = r_presc[DIV_LOG2-1 -: BRIGHT_W];
    assign w_an_on = (w_phase <= bright) && (r_presc != '0) && !w_term;

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_dp         <= DP_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_on ? ~(c_one_hot0 << r_idx) : '1;
            r_seg        <= w_visible ? w_font : SEG_BLANK;
            r_dp         <= w_sel_blank ? DP_OFF : ~w_sel_dp;
            r_frame_tick <= w_wrap;
        end
    end

    assign an             = r_an;
    assign seg            = r_seg;
    assign dp             = r_dp;
    assign frame_tick     = r_frame_tick;
    assign update_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_scan_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_display_ctrl
//  Description : Scoreboard bench for scan_display_ctrl; a 4-digit and a
//                5-digit instance with 16-cycle digit slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_display_ctrl;

    localparam logic [6:0] F0  = 7'b0000001;
    localparam logic [6:0] F1  = 7'b1001111;
    localparam logic [6:0] F2  = 7'b0010010;
    localparam logic [6:0] F3  = 7'b0000110;
    localparam logic [6:0] F4  = 7'b1001100;
    localparam logic [6:0] FA  = 7'b0001000;
    localparam logic [6:0] FF  = 7'b0111000;
    localparam logic [6:0] BLK = 7'h7F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] digits_a;
    logic [3:0]  dpin_a, blank_a, an_a;
    logic        lz_a, upd_a, dp_a, tick_a, pend_a;
    logic [2:0]  bright_a;
    logic [6:0]  seg_a;

    logic [19:0] digits_b;
    logic [4:0]  dpin_b, blank_b, an_b;
    logic        lz_b, upd_b, dp_b, tick_b, pend_b;
    logic [2:0]  bright_b;
    logic [6:0]  seg_b;

    scan_display_ctrl #(.NUM_DIGITS(4), .DIV_LOG2(4)) u_dut_a (
        .clk(clk), .reset(reset), .digits_in(digits_a), .dp_in(dpin_a),
        .blank_in(blank_a), .lz_en(lz_a), .bright(bright_a), .update_req(upd_a),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(tick_a),
        .update_pending(pend_a)
    );

    scan_display_ctrl #(.NUM_DIGITS(5), .DIV_LOG2(4)) u_dut_b (
        .clk(clk), .reset(reset), .digits_in(digits_b), .dp_in(dpin_b),
        .blank_in(blank_b), .lz_en(lz_b), .bright(bright_b), .update_req(upd_b),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(tick_b),
        .update_pending(pend_b)
    );

    typedef struct packed {
        logic [15:0] an;
        logic [6:0]  seg;
        logic        dp;
        logic [7:0]  duty;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [6:0] s, input logic d, input int du);
        exp_t e;
        e      = '0;
        e.an   = 16'hFFFF;
        e.an[k] = 1'b0;
        e.seg  = s;
        e.dp   = d;
        e.duty = 8'(du);
        return e;
    endfunction

    // Monitor state: one lit interval per digit slot, compared when it ends
    logic [15:0] prev_an [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] cur_an  [2];
    logic [6:0]  cur_seg [2];
    logic        cur_dp  [2];
    int          lit     [2];
    logic [15:0] mon_now;
    int          last_a = -1;
    int          last_b = -1;

    task automatic close_slot(input int d);
        exp_t e;
        bool_match: begin
            if (d == 0) begin
                if (q_a.size() == 0 || q_a[0].an != cur_an[0]) disable bool_match;
                e = q_a.pop_front();
            end else begin
                if (q_b.size() == 0 || q_b[0].an != cur_an[1]) disable bool_match;
                e = q_b.pop_front();
            end
            check($sformatf("seg dut%0d an=%h", d, cur_an[d]), 32'(cur_seg[d]), 32'(e.seg));
            check($sformatf("dp dut%0d an=%h", d, cur_an[d]), 32'(cur_dp[d]), 32'(e.dp));
            check($sformatf("duty dut%0d an=%h", d, cur_an[d]), 32'(lit[d]), 32'(e.duty));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_now = (d == 0) ? {12'hFFF, an_a} : {11'h7FF, an_b};
            if (mon_now != 16'hFFFF) begin
                if (prev_an[d] == 16'hFFFF) begin
                    cur_an[d]  = mon_now;
                    cur_seg[d] = (d == 0) ? seg_a : seg_b;
                    cur_dp[d]  = (d == 0) ? dp_a : dp_b;
                    lit[d]     = 1;
                end else begin
                    lit[d]++;
                end
            end else if (prev_an[d] != 16'hFFFF) begin
                close_slot(d);
            end
            prev_an[d] = mon_now;
        end
        if (reset) begin
            last_a = -1;
            last_b = -1;
        end else begin
            if (tick_a === 1'b1) begin
                if (last_a >= 0) check("frame_tick period A", 32'(cyc - last_a), 32'd64);
                last_a = cyc;
            end
            if (tick_b === 1'b1) begin
                if (last_b >= 0) check("frame_tick period B", 32'(cyc - last_b), 32'd80);
                last_b = cyc;
            end
        end
    end

    task automatic wait_tick(input int d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (d == 0) ? (tick_a === 1'b1) : (tick_b === 1'b1);
        end
        check($sformatf("frame_tick seen dut%0d", d), 32'(got), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        digits_a = '0; dpin_a = '0; blank_a = '0; lz_a = 1'b0; bright_a = 3'd7; upd_a = 1'b0;
        digits_b = '0; dpin_b = '0; blank_b = '0; lz_b = 1'b0; bright_b = 3'd7; upd_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset an A", 32'(an_a), 32'hF);
        check("reset seg A", 32'(seg_a), 32'(BLK));
        check("reset dp A", 32'(dp_a), 32'd1);
        check("reset tick A", 32'(tick_a), 32'd0);
        check("reset pending A", 32'(pend_a), 32'd0);
        check("reset an B", 32'(an_b), 32'h1F);

        // First frame after release: shadow is all zero, full brightness
        reset = 1'b0;
        for (int k = 0; k < 4; k++) q_a.push_back(mk(k, F0, 1'b1, 14));
        wait_tick(0);

        // Mid-frame request: current frame must finish with old data
        repeat (20) @(negedge clk);
        digits_a = 16'h12AF;
        upd_a    = 1'b1;
        q_a.push_back(mk(2, F0, 1'b1, 14));
        q_a.push_back(mk(3, F0, 1'b1, 14));
        @(negedge clk);
        upd_a = 1'b0;
        check("pending after req", 32'(pend_a), 32'd1);
        repeat (20) @(negedge clk);
        check("pending held before wrap", 32'(pend_a), 32'd1);
        upd_a = 1'b1;
        @(negedge clk);
        upd_a = 1'b0;
        wait_tick(0);
        check("pending cleared at wrap", 32'(pend_a), 32'd0);
        q_a.push_back(mk(0, FF, 1'b1, 14));
        q_a.push_back(mk(1, FA, 1'b1, 14));
        q_a.push_back(mk(2, F2, 1'b1, 14));
        q_a.push_back(mk(3, F1, 1'b1, 14));

        // Leading-zero suppression with dp on a suppressed digit, brightness 3
        wait_tick(0);
        digits_a = 16'h0030;
        dpin_a   = 4'b1000;
        lz_a     = 1'b1;
        bright_a = 3'd3;
        upd_a    = 1'b1;
        @(negedge clk);
        upd_a = 1'b0;
        wait_tick(0);
        q_a.push_back(mk(0, F0, 1'b1, 7));
        q_a.push_back(mk(1, F3, 1'b1, 7));
        q_a.push_back(mk(2, BLK, 1'b1, 7));
        q_a.push_back(mk(3, BLK, 1'b0, 7));

        // Request on the exact wrap cycle: all-zero value, brightness 0
        repeat (63) @(posedge clk);
        @(negedge clk);
        digits_a = 16'h0000;
        dpin_a   = 4'b0000;
        bright_a = 3'd0;
        upd_a    = 1'b1;
        @(negedge clk);
        upd_a = 1'b0;
        check("tick after coincident wrap", 32'(tick_a), 32'd1);
        check("pending stays 0 on wrap req", 32'(pend_a), 32'd0);
        q_a.push_back(mk(0, F0, 1'b1, 1));
        for (int k = 1; k < 4; k++) q_a.push_back(mk(k, BLK, 1'b1, 1));

        // Reset in the middle of a lit slot; request during reset is ignored
        wait_tick(0);
        lz_a     = 1'b0;
        bright_a = 3'd7;
        repeat (20) @(negedge clk);
        reset    = 1'b1;
        digits_a = 16'h5555;
        upd_a    = 1'b1;
        @(negedge clk);
        check("mid reset an A", 32'(an_a), 32'hF);
        check("mid reset seg A", 32'(seg_a), 32'(BLK));
        check("mid reset dp A", 32'(dp_a), 32'd1);
        check("mid reset tick A", 32'(tick_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        upd_a = 1'b0;
        for (int k = 0; k < 4; k++) q_a.push_back(mk(k, F0, 1'b1, 14));
        @(negedge clk);
        check("pending after reset req", 32'(pend_a), 32'd0);
        @(negedge clk);
        check("scan restarts at digit 0", 32'(an_a), 32'hE);

        // Five-digit instance: wrap at 4, blanked digit 2 hides its dp
        digits_b = 20'h01234;
        dpin_b   = 5'b00100;
        blank_b  = 5'b00100;
        upd_b    = 1'b1;
        @(negedge clk);
        upd_b = 1'b0;
        check("pending B", 32'(pend_b), 32'd1);
        wait_tick(1);
        for (int f = 0; f < 2; f++) begin
            q_b.push_back(mk(0, F4, 1'b1, 14));
            q_b.push_back(mk(1, F3, 1'b1, 14));
            q_b.push_back(mk(2, BLK, 1'b1, 14));
            q_b.push_back(mk(3, F1, 1'b1, 14));
            q_b.push_back(mk(4, F0, 1'b1, 14));
        end

        // Drain both scoreboards within a bounded time
        for (int i = 0; i < 400 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        check("scoreboard A drained", 32'(q_a.size()), 32'd0);
        check("scoreboard B drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
